// File: rtl/pingpong_operand_ram.sv
// rtl/pingpong_operand_ram.sv - two-bank ping-pong operand buffer with done/release handoff
module pingpong_operand_ram #(
    parameter int Output_width  = 16,
    parameter int Address_width = 4,
    parameter int Length        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [Address_width-1:0] wr_addr,
    input  logic [Output_width-1:0]  wr_data,
    input  logic                     wr_done,
    output logic                     wr_ready,
    input  logic                     rd_en,
    input  logic [Address_width-1:0] rd_addr,
    output logic [Output_width-1:0]  rd_data,
    output logic                     rd_valid,
    input  logic                     rd_release,
    output logic                     rd_ready,
    output logic [1:0]               level,
    input  logic                     err_clr,
    output logic                     err_wr,
    output logic                     err_rd
);
    // One extra bit so Length == 2**Address_width is representable.
    localparam logic [Address_width:0] LEN = (Address_width + 1)'(Length);

    logic [Output_width-1:0] mem [2][Length];
    logic [1:0]              full;
    logic                    wptr;
    logic                    rptr;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_ok;
    logic                    wr_viol;
    logic                    rd_viol;
    logic                    bank_in;
    logic                    bank_out;

    assign wr_ready    = ~full[wptr];
    assign rd_ready    = full[rptr];
    assign level       = {1'b0, full[0]} + {1'b0, full[1]};

    assign wr_in_range = {1'b0, wr_addr} < LEN;
    assign rd_in_range = {1'b0, rd_addr} < LEN;
    assign wr_ok       = wr_en & wr_ready & wr_in_range;
    assign bank_in     = wr_done & wr_ready;
    assign bank_out    = rd_release & rd_ready;
    assign wr_viol     = (wr_en & ~(wr_ready & wr_in_range)) | (wr_done & ~wr_ready);
    assign rd_viol     = (rd_en & ~(rd_ready & rd_in_range)) | (rd_release & ~rd_ready);

    // The write bank is never full, so a same-cycle wr_en lands before the pointer moves.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr][wr_addr] <= wr_data;
        end
    end

    // wptr and rptr always address different banks whenever both handoffs are legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (bank_in) begin
                full[wptr] <= 1'b1;
                wptr       <= ~wptr;
            end
            if (bank_out) begin
                full[rptr] <= 1'b0;
                rptr       <= ~rptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err_wr   <= 1'b0;
            err_rd   <= 1'b0;
        end else begin
            if (rd_en && rd_ready) begin
                rd_valid <= 1'b1;
                rd_data  <= rd_in_range ? mem[rptr][rd_addr] : '0;
            end else begin
                rd_valid <= 1'b0;
            end
            // A violation in the clearing cycle keeps the flag set.
            err_wr <= (err_wr & ~err_clr) | wr_viol;
            err_rd <= (err_rd & ~err_clr) | rd_viol;
        end
    end
endmodule

// File: tb/tb_pingpong_operand_ram.sv
// tb/tb_pingpong_operand_ram.sv - directed self-checking bench for pingpong_operand_ram
module tb_pingpong_operand_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        a_wr_en = 0, a_wr_done = 0, a_rd_en = 0, a_rd_release = 0, a_err_clr = 0;
    logic [3:0]  a_wr_addr = 0, a_rd_addr = 0;
    logic [15:0] a_wr_data = 0, a_rd_data;
    logic        a_wr_ready, a_rd_ready, a_rd_valid, a_err_wr, a_err_rd;
    logic [1:0]  a_level;

    logic        b_wr_en = 0, b_wr_done = 0, b_rd_en = 0, b_rd_release = 0, b_err_clr = 0;
    logic [3:0]  b_wr_addr = 0, b_rd_addr = 0;
    logic [15:0] b_wr_data = 0, b_rd_data;
    logic        b_wr_ready, b_rd_ready, b_rd_valid, b_err_wr, b_err_rd;
    logic [1:0]  b_level;

    always #5 clk = ~clk;

    pingpong_operand_ram #(.Output_width(16), .Address_width(4), .Length(16)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_done(a_wr_done),
        .wr_ready(a_wr_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_release(a_rd_release), .rd_ready(a_rd_ready),
        .level(a_level), .err_clr(a_err_clr), .err_wr(a_err_wr), .err_rd(a_err_rd)
    );

    pingpong_operand_ram #(.Output_width(16), .Address_width(4), .Length(12)) u_dut_short (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_done(b_wr_done),
        .wr_ready(b_wr_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_release(b_rd_release), .rd_ready(b_rd_ready),
        .level(b_level), .err_clr(b_err_clr), .err_wr(b_err_wr), .err_rd(b_err_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        a_wr_en = 1; a_wr_addr = addr; a_wr_data = data;
        step();
        a_wr_en = 0;
    endtask

    task automatic done();
        a_wr_done = 1;
        step();
        a_wr_done = 0;
    endtask

    task automatic release_bank();
        a_rd_release = 1;
        step();
        a_rd_release = 0;
    endtask

    task automatic rd(input logic [3:0] addr);
        a_rd_en = 1; a_rd_addr = addr;
        step();
        a_rd_en = 0;
    endtask

    initial begin
        step();
        step();
        check("rst_wr_ready", 32'(a_wr_ready), 32'd1);
        check("rst_rd_ready", 32'(a_rd_ready), 32'd0);
        check("rst_level",    32'(a_level),    32'd0);
        check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        check("rst_rd_data",  32'(a_rd_data),  32'd0);
        check("rst_errs",     32'({a_err_wr, a_err_rd}), 32'd0);
        rst = 0;
        step();

        for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        done();
        check("fill0_level",    32'(a_level),    32'd1);
        check("fill0_rd_ready", 32'(a_rd_ready), 32'd1);
        check("fill0_wr_ready", 32'(a_wr_ready), 32'd1);
        rd(4'd5);
        check("rd5_data",  32'(a_rd_data),  32'h1005);
        check("rd5_valid", 32'(a_rd_valid), 32'd1);
        step();
        check("idle_valid", 32'(a_rd_valid), 32'd0);
        check("idle_hold",  32'(a_rd_data),  32'h1005);

        // Fill bank1 while reading bank0; last write coincides with wr_done.
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1; a_wr_addr = 4'(i);
            a_wr_data = (i == 15) ? 16'hBEEF : 16'h2000 + 16'(i);
            a_wr_done = (i == 15);
            a_rd_en = 1; a_rd_addr = 4'(i);
            step();
            check("ovl_rd_data", 32'(a_rd_data), 32'h1000 + 32'(i));
        end
        a_wr_en = 0; a_wr_done = 0; a_rd_en = 0;
        check("full_level",    32'(a_level),    32'd2);
        check("full_wr_ready", 32'(a_wr_ready), 32'd0);
        check("full_err_wr",   32'(a_err_wr),   32'd0);

        wr(4'd3, 16'hDEAD);
        check("bp_err_wr", 32'(a_err_wr), 32'd1);
        release_bank();
        check("rel_level",    32'(a_level),    32'd1);
        check("rel_wr_ready", 32'(a_wr_ready), 32'd1);
        rd(4'd3);
        check("b1_addr3", 32'(a_rd_data), 32'h2003);
        rd(4'd15);
        check("b1_addr15", 32'(a_rd_data), 32'hBEEF);

        // Same-cycle done and release at level 1.
        wr(4'd0, 16'h3000);
        wr(4'd7, 16'h3007);
        a_wr_done = 1; a_rd_release = 1;
        step();
        a_wr_done = 0; a_rd_release = 0;
        check("swap_level",    32'(a_level),    32'd1);
        check("swap_wr_ready", 32'(a_wr_ready), 32'd1);
        check("swap_rd_ready", 32'(a_rd_ready), 32'd1);
        rd(4'd7);
        check("swap_rd7", 32'(a_rd_data), 32'h3007);
        wr(4'd0, 16'h4000);
        done();
        check("swap2_level",  32'(a_level),  32'd2);
        check("sticky_err_wr", 32'(a_err_wr), 32'd1);

        release_bank();
        rd(4'd0);
        check("b1_addr0", 32'(a_rd_data), 32'h4000);
        release_bank();
        check("empty_level",    32'(a_level),    32'd0);
        check("empty_rd_ready", 32'(a_rd_ready), 32'd0);
        rd(4'd1);
        check("empty_err_rd",   32'(a_err_rd),   32'd1);
        check("empty_rd_valid", 32'(a_rd_valid), 32'd0);
        a_err_clr = 1;
        step();
        check("clr_errs", 32'({a_err_wr, a_err_rd}), 32'd0);
        a_rd_release = 1;
        step();
        a_err_clr = 0; a_rd_release = 0;
        check("clr_vs_viol", 32'({a_err_wr, a_err_rd}), 32'b01);
        a_err_clr = 1;
        step();
        a_err_clr = 0;
        check("clr_again", 32'(a_err_rd), 32'd0);

        // Async reset mid-read with a partially filled write bank.
        wr(4'd2, 16'h6002);
        done();
        wr(4'd0, 16'h7000);
        rd(4'd2);
        check("pre_rst_data",  32'(a_rd_data),  32'h6002);
        check("pre_rst_valid", 32'(a_rd_valid), 32'd1);
        #2 rst = 1;
        #1;
        check("arst_rd_valid", 32'(a_rd_valid), 32'd0);
        check("arst_rd_data",  32'(a_rd_data),  32'd0);
        check("arst_level",    32'(a_level),    32'd0);
        check("arst_ready",    32'({a_wr_ready, a_rd_ready}), 32'b10);
        rst = 0;
        step();
        wr(4'd4, 16'h5004);
        done();
        check("post_rst_ready", 32'(a_rd_ready), 32'd1);
        rd(4'd4);
        check("post_rst_data", 32'(a_rd_data), 32'h5004);

        // Length=12 instance: address bounds.
        b_wr_en = 1; b_wr_addr = 4'd11; b_wr_data = 16'h0B11;
        step();
        check("short_wr11_err", 32'(b_err_wr), 32'd0);
        b_wr_addr = 4'd13; b_wr_data = 16'hDEAD;
        step();
        b_wr_en = 0;
        check("short_wr13_err", 32'(b_err_wr), 32'd1);
        b_wr_done = 1;
        step();
        b_wr_done = 0;
        check("short_level", 32'({b_level, b_wr_ready, b_rd_ready}), 32'b0111);
        b_rd_en = 1; b_rd_addr = 4'd11;
        step();
        check("short_rd11",     32'(b_rd_data), 32'h0B11);
        check("short_rd11_err", 32'(b_err_rd),  32'd0);
        b_rd_addr = 4'd12;
        step();
        b_rd_en = 0;
        check("short_rd12_data",  32'(b_rd_data),  32'd0);
        check("short_rd12_valid", 32'(b_rd_valid), 32'd1);
        check("short_rd12_err",   32'(b_err_rd),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pingpong_operand_ram.md
Name: pingpong_operand_ram

Overview:
- Parametrised two-bank ping-pong operand buffer for feeding the systolic array; successor to the single-bank dual-port RAM.
- Writer (host/DMA side) fills one bank while the array-side reader consumes the other.
- Bank ownership swaps through a done/release handshake, with occupancy tracking, a registered read pipeline and sticky protocol-error flags.
- Single clock domain.

Parameters:
- Output_width, 16, data word width in bits.
- Address_width, 4, address width per bank.
- Length, 16, words per bank; must satisfy 1 <= Length <= 2**Address_width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe into the current write bank.
- wr_addr  input  Address_width  write address within bank.
- wr_data  input  Output_width  write data.
- wr_done  input  1  writer finished current bank; hand it to the reader.
- wr_ready  output  1  current write bank is free.
- rd_en  input  1  read strobe from the current read bank.
- rd_addr  input  Address_width  read address within bank.
- rd_data  output  Output_width  registered read data.
- rd_valid  output  1  rd_data updated this cycle.
- rd_release  input  1  reader finished current bank; return it to the writer.
- rd_ready  output  1  current read bank is full.
- level  output  2  number of full banks, 0..2.
- err_clr  input  1  synchronous clear of the sticky error flags.
- err_wr  output  1  sticky: writer protocol or address violation.
- err_rd  output  1  sticky: reader protocol or address violation.

Behaviour:
- State:
  - full[1:0]: one flag per bank.
  - wptr, rptr: 1-bit bank pointers.
  - Storage: 2 x Length words. RAM contents are not reset.
- Reset (async, rst=1):
  - full=0, wptr=0, rptr=0.
  - rd_data=0, rd_valid=0, err_wr=0, err_rd=0.
  - Outputs therefore read wr_ready=1, rd_ready=0, level=0.
- Combinational outputs:
  - wr_ready = ~full[wptr].
  - rd_ready = full[rptr].
  - level = full[0] + full[1].
- Write path:
  - wr_en & wr_ready & wr_addr<Length: bank[wptr][wr_addr] <= wr_data at the clock edge.
  - wr_en & ~wr_ready: write dropped; err_wr <= 1.
  - wr_en & wr_addr>=Length: write dropped; err_wr <= 1.
- Write handoff:
  - wr_done & wr_ready: full[wptr] <= 1 and wptr toggles.
  - wr_en in the same cycle as wr_done lands in the outgoing bank before the swap.
  - wr_done & ~wr_ready: ignored; err_wr <= 1.
- Read path:
  - Latency is 1 cycle.
  - rd_en & rd_ready & rd_addr<Length: rd_data <= bank[rptr][rd_addr]; rd_valid <= 1 on the next cycle.
  - rd_en & ~rd_ready: no read; rd_valid <= 0; err_rd <= 1.
  - rd_en & rd_addr>=Length: rd_data <= 0; rd_valid <= 1; err_rd <= 1.
  - rd_valid is 0 in any cycle following no accepted read.
  - rd_data holds its last value when no read occurs.
- Read release:
  - rd_release & rd_ready: full[rptr] <= 0 and rptr toggles.
  - rd_en in the same cycle as rd_release reads the outgoing bank.
  - rd_release & ~rd_ready: ignored; err_rd <= 1.
- Simultaneous events:
  - wr_done and rd_release in the same cycle both take effect; they always target different banks.
  - level may go 1->1 (one bank in, one bank out).
- Full and empty:
  - level=2: wr_ready=0 until a release.
  - level=0: rd_ready=0 until a done.
  - A released bank becomes writable on the very next cycle.
- Read/write collision: the write bank and the read bank are never the same bank while both are legal, so there is no read-during-write hazard.
- Error flags:
  - err_clr clears both flags.
  - A new violation in the same cycle as err_clr wins, leaving the flag set.
- Reset mid-operation: all handoff state is lost immediately; any in-flight rd_valid drops asynchronously.

Test Plan:
- Basic ping-pong: reset; write bank0 addr 0..15 with 0x1000+i; pulse wr_done -> level=1, rd_ready=1, wr_ready=1. Read addr 5 -> next cycle rd_data=0x1005, rd_valid=1.
- Overlap: fill bank1 with 0x2000+i while reading bank0; wr_done -> level=2, wr_ready=0. rd_release -> level=1, next reads return 0x20xx.
- Backpressure errors: at level=2 issue wr_en to addr 3 with 0xDEAD -> err_wr=1 and the bank contents are unchanged. At level=0 issue rd_en -> err_rd=1, rd_valid=0. err_clr -> both flags 0.
- Same-cycle events:
  - wr_en (addr 15, 0xBEEF) together with wr_done -> a read of addr 15 returns 0xBEEF.
  - At level=1, wr_done and rd_release in the same cycle -> level stays 1 and both pointers toggle.
- Address bound with Length=12, Address_width=4: write addr 13 -> err_wr=1. Read addr 12 -> rd_data=0, rd_valid=1, err_rd=1.
- Async reset: assert rst mid-fill at level=1 during a read -> outputs go to reset values without a clock edge. After release, a fresh fill and read cycle works from bank0.
